// File: rtl/load_data_ext_pkg.sv
// Shared instruction definitions for the load/store datapath: opcodes and request legality.
package load_data_ext_pkg;

  localparam logic [5:0] OpLb  = 6'b100000;
  localparam logic [5:0] OpLh  = 6'b100001;
  localparam logic [5:0] OpLw  = 6'b100011;
  localparam logic [5:0] OpLbu = 6'b100100;
  localparam logic [5:0] OpLhu = 6'b100101;
  localparam logic [5:0] OpSb  = 6'b101000;
  localparam logic [5:0] OpSh  = 6'b101001;
  localparam logic [5:0] OpSw  = 6'b101011;

  localparam int unsigned CntW = 8;

  function automatic logic is_load(input logic [5:0] op);
    logic r;
    case (op)
      OpLb, OpLh, OpLw, OpLbu, OpLhu: r = 1'b1;
      default:                        r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    logic r;
    case (op)
      OpSb, OpSh, OpSw: r = 1'b1;
      default:          r = 1'b0;
    endcase
    return r;
  endfunction

  // Natural alignment: words on 4-byte, halves on 2-byte boundaries.
  function automatic logic load_legal(input logic [5:0] op, input logic [1:0] addr_lo);
    logic r;
    case (op)
      OpLw:         r = (addr_lo == 2'b00);
      OpLh, OpLhu:  r = ~addr_lo[0];
      OpLb, OpLbu:  r = 1'b1;
      default:      r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/load_extract.sv
// Little-endian lane select plus sign/zero extension of a loaded memory word.
module load_extract
  import load_data_ext_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  output logic [31:0] value
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    unique case (addr_lo)
      2'b00: byte_lane = word[7:0];
      2'b01: byte_lane = word[15:8];
      2'b10: byte_lane = word[23:16];
      2'b11: byte_lane = word[31:24];
      default: byte_lane = word[7:0];
    endcase
    half_lane = addr_lo[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    case (op)
      OpLb:    value = {{24{byte_lane[7]}}, byte_lane};
      OpLbu:   value = {24'h0, byte_lane};
      OpLh:    value = {{16{half_lane[15]}}, half_lane};
      OpLhu:   value = {16'h0, half_lane};
      OpLw:    value = word;
      default: value = 32'h0;
    endcase
  end

endmodule

// File: rtl/load_data_ext.sv
// Load unit: accepts a load request, waits for the memory word with a timeout,
// and returns the lane-selected, extended result.
module load_data_ext
  import load_data_ext_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [5:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] mem_rdata,
  input  logic        mem_valid,
  output logic        busy,
  output logic [31:0] rdata,
  output logic        done,
  output logic        err
);

  typedef enum logic {
    StIdle,
    StWait
  } state_e;

  localparam logic [CntW-1:0] CntLimit = CntW'(TIMEOUT_CYC - 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [5:0]        op_q, op_d;
  logic [1:0]        addr_q, addr_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [31:0]       ext_value;

  load_extract u_extract (
    .op      (op_q),
    .addr_lo (addr_q),
    .word    (mem_rdata),
    .value   (ext_value)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (load_legal(op, addr_lo)) begin
            op_d    = op;
            addr_d  = addr_lo;
            cnt_d   = '0;
            state_d = StWait;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StWait: begin
        // mem_valid takes priority over a timeout landing in the same cycle.
        if (mem_valid) begin
          rdata_d = ext_value;
          done_d  = 1'b1;
          state_d = StIdle;
        end else if (cnt_q == CntLimit) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      addr_q  <= '0;
      rdata_q <= 32'h0000_0000;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy  = (state_q == StWait);
  assign rdata = rdata_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule

// File: tb/tb_load_data_ext.sv
// Randomized scoreboard bench for load_data_ext against an arithmetic reference model.
module tb_load_data_ext;

  localparam int unsigned Timeout = 16;
  localparam logic [5:0] LB = 6'b100000, LH = 6'b100001, LW = 6'b100011;
  localparam logic [5:0] LBU = 6'b100100, LHU = 6'b100101;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [5:0]  op;
  logic [1:0]  addr_lo;
  logic [31:0] mem_rdata;
  logic        mem_valid;
  logic        busy;
  logic [31:0] rdata;
  logic        done;
  logic        err;

  load_data_ext #(.TIMEOUT_CYC(Timeout)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .addr_lo   (addr_lo),
    .mem_rdata (mem_rdata),
    .mem_valid (mem_valid),
    .busy      (busy),
    .rdata     (rdata),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] rdata_m = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
  endtask

  // Reference model: legality and extracted value from the load rules directly.
  function automatic bit ref_legal(input logic [5:0] o, input logic [1:0] a);
    if (o == LW) return a == 2'd0;
    if (o == LH || o == LHU) return (a % 2) == 0;
    return (o == LB || o == LBU);
  endfunction

  function automatic logic [31:0] ref_value(input logic [5:0] o, input logic [1:0] a,
                                            input logic [31:0] w);
    int unsigned b, h;
    b = (w >> (8 * a)) & 32'hFF;
    h = (w >> (16 * (a / 2))) & 32'hFFFF;
    if (o == LB)  return (b >= 128) ? b - 256 : b;
    if (o == LBU) return b;
    if (o == LH)  return (h >= 32768) ? h - 65536 : h;
    if (o == LHU) return h;
    return w;
  endfunction

  // Monitor: pop and compare whenever the DUT presents a pulse.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (done === 1'b1 || err === 1'b1)) begin
      exp_t e;
      check("done_err_exclusive", 32'(done & err), 32'h0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {30'h0, done, err}, 32'h0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind_err", 32'(err), 32'(e.is_err));
        check("pulse_cycle", 32'(cyc), 32'(e.cyc));
        check("rdata_at_pulse", rdata, e.data);
      end
    end
  end

  task automatic push(input bit is_err, input int at);
    exp_t e;
    e.is_err = is_err;
    e.data   = rdata_m;
    e.cyc    = at;
    exp_q.push_back(e);
  endtask

  // d = idle WAIT cycles before mem_valid; d >= Timeout means memory never answers.
  task automatic run_load(input logic [5:0] o, input logic [1:0] a, input logic [31:0] w,
                          input int d, input bit inject);
    int n;
    @(posedge clk); #1;
    start = 1'b1; op = o; addr_lo = a; mem_valid = 1'b0; mem_rdata = $urandom;
    n = cyc;
    @(posedge clk); #1;
    start = 1'b0; op = 6'($urandom); addr_lo = 2'($urandom);
    if (!ref_legal(o, a)) begin
      push(1'b1, n + 1);
      check("busy_illegal", 32'(busy), 32'h0);
      return;
    end
    check("busy_wait", 32'(busy), 32'h1);
    for (int i = 0; i < ((d < Timeout) ? d : Timeout); i++) begin
      if (inject && i == 0) begin
        start = 1'b1; op = LBU; addr_lo = 2'($urandom);
      end
      mem_rdata = $urandom;
      @(posedge clk); #1;
      start = 1'b0;
    end
    if (d < Timeout) begin
      mem_valid = 1'b1; mem_rdata = w;
      rdata_m = ref_value(o, a, w);
      push(1'b0, n + 2 + d);
      @(posedge clk); #1;
      mem_valid = 1'b0;
    end else begin
      push(1'b1, n + 1 + Timeout);
    end
    check("busy_after", 32'(busy), 32'h0);
  endtask

  task automatic idle_gap(input bit noise);
    @(posedge clk); #1;
    mem_valid = noise; mem_rdata = $urandom;
    @(posedge clk); #1;
    mem_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] ops [5];
    logic [5:0] o;
    ops[0] = LB; ops[1] = LH; ops[2] = LW; ops[3] = LBU; ops[4] = LHU;
    rst_n = 1'b0; start = 1'b0; op = '0; addr_lo = '0; mem_rdata = '0; mem_valid = 1'b0;
    #3;
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_err", 32'(err), 32'h0);
    check("reset_rdata", rdata, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_load(LB, 2'd1, 32'h1234_80FF, 2, 1'b0);
    idle_gap(1'b0);
    check("lb_rdata", rdata, 32'hFFFF_FF80);
    run_load(LHU, 2'd2, 32'h8001_0000, 0, 1'b0);
    idle_gap(1'b1);
    check("lhu_rdata", rdata, 32'h0000_8001);
    run_load(LH, 2'd2, 32'h8001_0000, 4, 1'b0);
    idle_gap(1'b0);
    check("lh_rdata", rdata, 32'hFFFF_8001);
    run_load(LW, 2'd2, 32'hDEAD_BEEF, 0, 1'b0);
    idle_gap(1'b0);
    check("lw_misaligned_rdata", rdata, 32'hFFFF_8001);
    run_load(LW, 2'd0, 32'h0, 100, 1'b1);
    idle_gap(1'b1);
    check("timeout_rdata", rdata, 32'hFFFF_8001);
    run_load(LW, 2'd0, 32'hCAFE_F00D, Timeout - 1, 1'b0);
    idle_gap(1'b0);
    check("limit_rdata", rdata, 32'hCAFE_F00D);

    // Reset in the middle of WAIT, with an extra start already issued.
    @(posedge clk); #1;
    start = 1'b1; op = LBU; addr_lo = 2'd0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; op = LB;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_before_reset", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("midwait_reset_busy", 32'(busy), 32'h0);
    check("midwait_reset_rdata", rdata, 32'h0);
    rdata_m = 32'h0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_valid = 1'b1; mem_rdata = 32'h1111_1111;
    @(posedge clk); #1;
    mem_valid = 1'b0;
    check("post_reset_rdata", rdata, 32'h0);
    run_load(LBU, 2'd3, 32'hAB00_0000, 1, 1'b0);
    idle_gap(1'b0);
    check("lbu_rdata", rdata, 32'h0000_00AB);

    for (int t = 0; t < 40; t++) begin
      int d;
      o = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 4)];
      d = ($urandom_range(0, 9) == 0) ? $urandom_range(Timeout - 1, Timeout + 3)
                                      : $urandom_range(0, 6);
      run_load(o, 2'($urandom), $urandom, d, 1'($urandom));
      idle_gap(1'($urandom));
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/load_data_ext.md
LOAD_DATA_EXT -- requirements
Module: load_data_ext

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYC, 16, max cycles waited in WAIT for mem_valid before abort (legal range 2..255).
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start  in  1  load request, sampled in IDLE only.
REQ-005 SHALL have port: op  in  6  instr[31:26] of the load instruction, sampled with start.
REQ-006 SHALL have port: addr_lo  in  2  aluout[1:0], the byte offset, sampled with start.
REQ-007 SHALL have port: mem_rdata  in  32  aligned word returned by memory.
REQ-008 SHALL have port: mem_valid  in  1  mem_rdata valid this cycle.
REQ-009 SHALL have port: busy  out  1  high while in WAIT.
REQ-010 SHALL have port: rdata  out  32  extended load result, registered.
REQ-011 SHALL have port: done  out  1  one-cycle pulse when rdata is updated.
REQ-012 SHALL have port: err  out  1  one-cycle pulse on misaligned address, non-load op, or timeout.

Function
REQ-013 SHALL implement FSM states IDLE and WAIT only.
REQ-014 IDLE + start with legal request SHALL latch op and addr_lo, clear the timeout counter, and enter WAIT next edge.
REQ-015 IDLE + start with illegal request SHALL pulse err on the next cycle and stay in IDLE. Illegal means: op not LW/LH/LHU/LB/LBU; LW with addr_lo != 00; LH/LHU with addr_lo[0] = 1.
REQ-016 WAIT + mem_valid SHALL register the extracted value into rdata, pulse done in the following cycle, and return to IDLE.
REQ-017 Latency SHALL be 1 cycle from the mem_valid edge to done/rdata visible.
REQ-018 WAIT without mem_valid SHALL increment the counter. On reaching TIMEOUT_CYC-1 it SHALL pulse err, leave rdata unchanged, and return to IDLE.
REQ-019 If mem_valid arrives in the cycle the counter hits its limit, mem_valid SHALL win: done pulses and err does not.
REQ-020 start during WAIT SHALL be ignored. mem_valid during IDLE SHALL be ignored.
REQ-021 Lane select SHALL be little-endian, matching the store byte enables.
- Byte: addr_lo 00 -> [7:0], 01 -> [15:8], 10 -> [23:16], 11 -> [31:24].
- Half: addr_lo[1] = 0 -> [15:0], 1 -> [31:16].
- Word: [31:0].
REQ-022 LB/LH SHALL sign-extend to 32 bits. LBU/LHU SHALL zero-extend. LW SHALL pass through.
REQ-023 rdata SHALL hold its value between done pulses.
REQ-024 done and err SHALL never be high in the same cycle.

Reset
REQ-025 rst_n low SHALL immediately force: state IDLE, counter 0, busy 0, done 0, err 0, rdata 32'h0000_0000.
REQ-026 Reset asserted mid-WAIT SHALL abandon the request with no done or err pulse.
REQ-027 After reset release, the first start SHALL be accepted on the first rising edge.

Structure
REQ-028 Load opcodes (LW 100011, LH 100001, LHU 100101, LB 100000, LBU 100100) SHALL come from the shared instruction-definition include alongside the store opcodes.
REQ-029 FSM state encodings SHALL be local constants, not shared.
REQ-030 Lane select plus extension SHALL be a combinational sub-module load_extract (inputs op, addr_lo, word; output 32-bit value), instantiated once.

Verification
REQ-031 LB, addr_lo 01, mem_rdata 32'h1234_80FF, mem_valid 3 cycles after start -> done 1 cycle later, rdata 32'hFFFF_FF80.
REQ-032 LHU, addr_lo 10, mem_rdata 32'h8001_0000 -> rdata 32'h0000_8001. LH with the same inputs -> rdata 32'hFFFF_8001.
REQ-033 LW, addr_lo 10 -> err pulse next cycle, busy stays 0, rdata unchanged.
REQ-034 LW, addr_lo 00, no mem_valid, TIMEOUT_CYC 16 -> err after 16 cycles in WAIT, state IDLE, no done.
REQ-035 LBU in WAIT, second start mid-wait, then rst_n low for 1 cycle before mem_valid -> no done/err, rdata 0. A following LBU with mem_rdata 32'hAB00_0000 at addr_lo 11 -> rdata 32'h0000_00AB.
REQ-036 mem_valid coincident with the timeout limit -> done high, err low.
